// File: rtl/replay_fifo.sv
// replay_fifo: DEPTH x DATA_W FIFO with mark/rewind replay and a registered valid/ready output.
// Define FIFO_DROP_CNT_EN to build the saturating rejected-push counter on o_drop_cnt.
module replay_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1000,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_mark,
  input  logic              i_rewind,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_full,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic [PTR_W:0]    o_level,
  output logic [15:0]       o_drop_cnt
);

  localparam int unsigned CntW = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CntW-1:0]  cnt_t;

  localparam cnt_t DepthCnt = cnt_t'(DEPTH);
  localparam ptr_t LastPtr  = ptr_t'(DEPTH - 1);

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LastPtr) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  ptr_t wptr_q, wptr_d;
  ptr_t fptr_q, fptr_d;
  ptr_t hptr_q, hptr_d;
  ptr_t mptr_q, mptr_d;
  // Counts kept alongside the pointers so that 0 and DEPTH stay distinct.
  cnt_t ucnt_q, ucnt_d;  // written but not yet fetched
  cnt_t pcnt_q, pcnt_d;  // write-protected: wptr - mptr
  logic valid_q, valid_d;

  cnt_t lvl;
  logic full, push, pop, fetch, wr_en;

  always_comb begin
    lvl     = ucnt_q + cnt_t'(valid_q);
    full    = (pcnt_q == DepthCnt);
    push    = i_push && !full;
    pop     = valid_q && i_ready;
    fetch   = 1'b0;
    wr_en   = 1'b0;
    wptr_d  = wptr_q;
    fptr_d  = fptr_q;
    hptr_d  = hptr_q;
    mptr_d  = mptr_q;
    ucnt_d  = ucnt_q;
    pcnt_d  = pcnt_q;
    valid_d = valid_q;

    if (i_flush) begin
      wptr_d  = '0;
      fptr_d  = '0;
      hptr_d  = '0;
      mptr_d  = '0;
      ucnt_d  = '0;
      pcnt_d  = '0;
      valid_d = 1'b0;
    end else if (i_rewind) begin
      // Pop and mark are ignored; the output stage and any fetch are dropped.
      wr_en   = push;
      if (push) wptr_d = ptr_inc(wptr_q);
      fptr_d  = mptr_q;
      hptr_d  = mptr_q;
      valid_d = 1'b0;
      pcnt_d  = pcnt_q + cnt_t'(push);
      ucnt_d  = pcnt_q + cnt_t'(push);
    end else begin
      fetch   = (ucnt_q != '0) && (!valid_q || pop);
      wr_en   = push;
      if (push)  wptr_d = ptr_inc(wptr_q);
      if (fetch) fptr_d = ptr_inc(fptr_q);
      if (pop)   hptr_d = ptr_inc(hptr_q);
      ucnt_d  = ucnt_q + cnt_t'(push) - cnt_t'(fetch);
      valid_d = fetch || (valid_q && !pop);
      if (i_mark) begin
        mptr_d = pop ? ptr_inc(hptr_q) : hptr_q;
        pcnt_d = lvl - cnt_t'(pop) + cnt_t'(push);
      end else begin
        pcnt_d = pcnt_q + cnt_t'(push);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      fptr_q  <= '0;
      hptr_q  <= '0;
      mptr_q  <= '0;
      ucnt_q  <= '0;
      pcnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      fptr_q  <= fptr_d;
      hptr_q  <= hptr_d;
      mptr_q  <= mptr_d;
      ucnt_q  <= ucnt_d;
      pcnt_q  <= pcnt_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wptr_q] <= i_data;
  end

  // RAM read register doubles as the output stage; it only loads on a fetch.
  always_ff @(posedge clk) begin
    if (rst)        rdata_q <= '0;
    else if (fetch) rdata_q <= mem_q[fptr_q];
  end

  assign o_full  = full;
  assign o_valid = valid_q;
  assign o_data  = rdata_q;
  assign o_level = lvl;
  assign o_empty = (lvl == '0);

`ifdef FIFO_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (i_push && full && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign o_drop_cnt = drop_q;
`else
  assign o_drop_cnt = '0;
`endif

endmodule
